// File: rtl/xfer_pkg.sv
// Shared types and encodings for the SDRAM <-> SRAM row transfer sequencer.
// Mode encodings match what address_calc decodes on its sram_mode/sdram_mode inputs.
package xfer_pkg;

    localparam int XFER_DATA_W = 32;
    localparam int XFER_CNT_W  = 13;

    localparam logic SRAM_ROWCACHE = 1'b1;
    localparam logic SRAM_OUTPUT   = 1'b0;
    localparam logic SDRAM_READ    = 1'b1;
    localparam logic SDRAM_WRITE   = 1'b0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LD_RD = 3'd1,
        LD_WR = 3'd2,
        ST_RD = 3'd3,
        ST_WR = 3'd4,
        DONE  = 3'd5
    } xfer_state_t;

endpackage

// File: rtl/xfer_counter.sv
// Clearable up-counter whose at_last flag says the next increment reaches term,
// so the FSM can decide on the same edge that performs the increment.
module xfer_counter
    import xfer_pkg::*;
#(
    parameter int CNT_W = XFER_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] term,
    output logic             at_last
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    assign cnt_nxt = cnt + CNT_W'(1);
    assign at_last = (cnt_nxt == term);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt_nxt;
    end

endmodule

// File: rtl/row_transfer_seq.sv
// Frame sequencer: per row, load image_width words SDRAM->SRAM row cache, then
// store image_width-1 processed words SRAM output region->SDRAM, stepping address_calc.
module row_transfer_seq
    import xfer_pkg::*;
#(
    parameter int DATA_W = XFER_DATA_W,
    parameter int CNT_W  = XFER_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  image_width,
    input  logic [CNT_W-1:0]  row_count,
    output logic              ac_start_flag,
    output logic              ac_update,
    output logic              ac_sram_mode,
    output logic              ac_sdram_mode,
    output logic              sdram_req,
    output logic              sdram_we,
    output logic [DATA_W-1:0] sdram_wdata,
    input  logic [DATA_W-1:0] sdram_rdata,
    input  logic              sdram_ack,
    output logic              sram_req,
    output logic              sram_we,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic              sram_ack,
    output logic              busy,
    output logic              done,
    output logic              err
);

    xfer_state_t      state, state_nxt;
    logic [CNT_W-1:0] width_q, rows_q;
    logic [CNT_W-1:0] wrd_term;
    logic [DATA_W-1:0] data_buf;

    logic wrd_clr, wrd_inc, wrd_last;
    logic row_clr, row_inc, row_last;
    logic ld_from_sdram, ld_from_sram;
    logic upd_nxt, start_ok, start_bad;

    // Load phase counts the full row; store phase drops the last word.
    assign wrd_term = (state == LD_RD || state == LD_WR) ? width_q : width_q - CNT_W'(1);

    xfer_counter #(.CNT_W(CNT_W)) u_wrd_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (wrd_clr),
        .inc     (wrd_inc),
        .term    (wrd_term),
        .at_last (wrd_last)
    );

    xfer_counter #(.CNT_W(CNT_W)) u_row_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (row_clr),
        .inc     (row_inc),
        .term    (rows_q),
        .at_last (row_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        sdram_req     = 1'b0;
        sdram_we      = 1'b0;
        sram_req      = 1'b0;
        sram_we       = 1'b0;
        ac_sram_mode  = SRAM_OUTPUT;
        ac_sdram_mode = SDRAM_WRITE;
        done          = 1'b0;
        wrd_clr       = 1'b0;
        wrd_inc       = 1'b0;
        row_clr       = 1'b0;
        row_inc       = 1'b0;
        ld_from_sdram = 1'b0;
        ld_from_sram  = 1'b0;
        upd_nxt       = 1'b0;
        start_ok      = 1'b0;
        start_bad     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (image_width < CNT_W'(2) || row_count == '0) begin
                        start_bad = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        start_ok  = 1'b1;
                        wrd_clr   = 1'b1;
                        row_clr   = 1'b1;
                        state_nxt = LD_RD;
                    end
                end
            end
            LD_RD: begin
                sdram_req     = 1'b1;
                ac_sdram_mode = SDRAM_READ;
                ac_sram_mode  = SRAM_ROWCACHE;
                if (sdram_ack) begin
                    ld_from_sdram = 1'b1;
                    state_nxt     = LD_WR;
                end
            end
            LD_WR: begin
                sram_req      = 1'b1;
                sram_we       = 1'b1;
                ac_sdram_mode = SDRAM_READ;
                ac_sram_mode  = SRAM_ROWCACHE;
                if (sram_ack) begin
                    upd_nxt = 1'b1;
                    if (wrd_last) begin
                        wrd_clr   = 1'b1;
                        state_nxt = ST_RD;
                    end else begin
                        wrd_inc   = 1'b1;
                        state_nxt = LD_RD;
                    end
                end
            end
            ST_RD: begin
                sram_req = 1'b1;
                if (sram_ack) begin
                    ld_from_sram = 1'b1;
                    state_nxt    = ST_WR;
                end
            end
            ST_WR: begin
                sdram_req = 1'b1;
                sdram_we  = 1'b1;
                if (sdram_ack) begin
                    upd_nxt = 1'b1;
                    if (wrd_last) begin
                        wrd_clr   = 1'b1;
                        row_inc   = 1'b1;
                        state_nxt = row_last ? DONE : LD_RD;
                    end else begin
                        wrd_inc   = 1'b1;
                        state_nxt = ST_RD;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy        = (state != IDLE);
    assign sdram_wdata = data_buf;
    assign sram_wdata  = data_buf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_q       <= '0;
            rows_q        <= '0;
            data_buf      <= '0;
            ac_start_flag <= 1'b0;
            ac_update     <= 1'b0;
            err           <= 1'b0;
        end else begin
            ac_start_flag <= start_ok;
            ac_update     <= upd_nxt;
            if (start_ok) begin
                width_q <= image_width;
                rows_q  <= row_count;
                err     <= 1'b0;
            end else if (start_bad) begin
                err     <= 1'b1;
            end
            if (ld_from_sdram)
                data_buf <= sdram_rdata;
            else if (ld_from_sram)
                data_buf <= sram_rdata;
        end
    end

endmodule
